// File: rtl/axi4lite_pkg.sv
// Shared types and response codes for the AXI4-Lite memory slave.
// Imported by the interface users, the top and the testbench.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

endpackage

// File: rtl/axi4lite_slave_mem_if.sv
// AXI4-Lite bus bundle between a master and the memory slave.
// The slave modport is the mirror of the master modport.
interface axi4lite_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid,
        output bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid,
        input  bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4lite_ram.sv
// Word-organised storage with a byte-enabled write port and a
// registered read port; contents are deliberately left unreset.
module axi4lite_ram #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NB-1:0]     wbe,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Same-edge read of a word being written sees the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite slave backed by a small byte-writable memory.
// Independent write (AW/W/B) and read (AR/R) state machines.
module axi4lite_slave_mem
    import axi4lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16
) (
    input logic                 clk,
    input logic                 rst,
    axi4lite_slave_mem_if.slave bus
);
    localparam int NB  = DATA_W / 8;
    localparam int OFS = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> (OFS + IW)) == '0;
    endfunction

    function automatic logic [IW-1:0] widx(input logic [ADDR_W-1:0] a);
        return a[OFS +: IW];
    endfunction

    wstate_t             wstate;
    logic                aw_held;
    logic                w_held;
    logic [ADDR_W-1:0]   aw_q;
    logic [DATA_W-1:0]   wd_q;
    logic [NB-1:0]       ws_q;
    logic                bvalid_q;
    logic [1:0]          bresp_q;

    logic                awready;
    logic                wready;
    logic                aw_fire;
    logic                w_fire;
    logic                commit;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_data;
    logic [NB-1:0]       cur_strb;

    assign awready  = (wstate == W_IDLE) && !aw_held;
    assign wready   = (wstate == W_IDLE) && !w_held;
    assign aw_fire  = bus.awvalid && awready;
    assign w_fire   = bus.wvalid && wready;
    assign cur_addr = aw_held ? aw_q : bus.awaddr;
    assign cur_data = w_held ? wd_q : bus.wdata;
    assign cur_strb = w_held ? ws_q : bus.wstrb;
    assign commit   = (wstate == W_IDLE)
                    && (aw_held || aw_fire)
                    && (w_held || w_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate   <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_q     <= '0;
            wd_q     <= '0;
            ws_q     <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_held <= 1'b1;
                        aw_q    <= bus.awaddr;
                    end
                    if (w_fire) begin
                        w_held <= 1'b1;
                        wd_q   <= bus.wdata;
                        ws_q   <= bus.wstrb;
                    end
                    if (commit) begin
                        wstate   <= W_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= in_range(cur_addr) ? RESP_OKAY
                                                       : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (bvalid_q && bus.bready) begin
                        wstate   <= W_IDLE;
                        bvalid_q <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                    end
                end
            endcase
        end
    end

    rstate_t             rstate;
    logic                rvalid_q;
    logic [1:0]          rresp_q;
    logic                rerr_q;
    logic                arready;
    logic                ar_fire;
    logic [DATA_W-1:0]   ram_rdata;

    assign arready = (rstate == R_IDLE);
    assign ar_fire = bus.arvalid && arready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate   <= R_IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rerr_q   <= 1'b0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (ar_fire) begin
                        rstate   <= R_DATA;
                        rvalid_q <= 1'b1;
                        rerr_q   <= !in_range(bus.araddr);
                        rresp_q  <= in_range(bus.araddr) ? RESP_OKAY
                                                         : RESP_SLVERR;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && bus.rready) begin
                        rstate   <= R_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    axi4lite_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (commit && in_range(cur_addr)),
        .waddr (widx(cur_addr)),
        .wdata (cur_data),
        .wbe   (cur_strb),
        .re    (ar_fire && in_range(bus.araddr)),
        .raddr (widx(bus.araddr)),
        .rdata (ram_rdata)
    );

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rerr_q ? '0 : ram_rdata;
endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// Scoreboard testbench for axi4lite_slave_mem with a word-array
// reference model, directed corner cases and randomized traffic.
module tb_axi4lite_slave_mem;
    import axi4lite_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 16;
    localparam int NB     = DATA_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4lite_slave_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi4lite_slave_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] model [DEPTH];
    logic [1:0]        bq [$];
    logic [129:0]      rq [$];
    int errors = 0;
    int checks = 0;
    int bdone  = 0;
    int rdone  = 0;
    bit bp_en  = 1'b0;

    task automatic check(input string n, input logic [129:0] act,
                         input logic [129:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", n, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit inr(input logic [ADDR_W-1:0] a);
        return (a >> 8) == 0;
    endfunction

    // Monitor: pop the oldest expectation on every completed response.
    always @(negedge clk) begin
        if (!rst && bus.bvalid && bus.bready) begin
            if (bq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL b_extra: got=%h want=none", bus.bresp);
            end else begin
                check("bresp", {128'b0, bus.bresp}, {128'b0, bq.pop_front()});
            end
            bdone++;
        end
        if (!rst && bus.rvalid && bus.rready) begin
            if (rq.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL r_extra: got=%h want=none",
                         {bus.rresp, bus.rdata});
            end else begin
                check("rresp_rdata", {bus.rresp, bus.rdata}, rq.pop_front());
            end
            rdone++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            bus.bready = ($urandom_range(0, 3) != 0);
            bus.rready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_aw(input logic [ADDR_W-1:0] a, input int d);
        int t = 0;
        tick(d);
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        @(negedge clk);
        while (!bus.awready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("aw_accept", {129'b0, bus.awready}, 130'd1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DATA_W-1:0] dt,
                          input logic [NB-1:0] s, input int d);
        int t = 0;
        tick(d);
        bus.wdata  = dt;
        bus.wstrb  = s;
        bus.wvalid = 1'b1;
        @(negedge clk);
        while (!bus.wready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("w_accept", {129'b0, bus.wready}, 130'd1);
        @(posedge clk);
        #1;
        bus.wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [ADDR_W-1:0] a);
        int t = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        @(negedge clk);
        while (!bus.arready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ar_accept", {129'b0, bus.arready}, 130'd1);
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic exp_write(input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] dt,
                             input logic [NB-1:0] s);
        if (inr(a)) begin
            bq.push_back(RESP_OKAY);
            for (int b = 0; b < NB; b++)
                if (s[b]) model[a[7:4]][b*8 +: 8] = dt[b*8 +: 8];
        end else begin
            bq.push_back(RESP_SLVERR);
        end
    endtask

    function automatic logic [129:0] exp_read(input logic [ADDR_W-1:0] a);
        logic [129:0] e;
        if (inr(a)) e = {RESP_OKAY, model[a[7:4]]};
        else        e = {RESP_SLVERR, 128'b0};
        rq.push_back(e);
        return e;
    endfunction

    task automatic wait_b(input int target);
        int t = 0;
        while (bdone < target && t < 200) begin
            tick(1);
            t++;
        end
        check("b_done", {129'b0, bdone >= target}, 130'd1);
    endtask

    task automatic wait_r(input int target);
        int t = 0;
        while (rdone < target && t < 200) begin
            tick(1);
            t++;
        end
        check("r_done", {129'b0, rdone >= target}, 130'd1);
    endtask

    // wlead > 0: W leads AW by wlead cycles; wlead < 0: AW leads W.
    task automatic do_write(input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] dt,
                            input logic [NB-1:0] s, input int wlead);
        int tgt = bdone + 1;
        exp_write(a, dt, s);
        fork
            send_aw(a, wlead > 0 ? wlead : 0);
            send_w(dt, s, wlead < 0 ? -wlead : 0);
        join
        check("b_latency", {129'b0, bus.bvalid}, 130'd1);
        wait_b(tgt);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        int tgt = rdone + 1;
        void'(exp_read(a));
        send_ar(a);
        wait_r(tgt);
    endtask

    task automatic do_both(input logic [ADDR_W-1:0] wa,
                           input logic [DATA_W-1:0] dt,
                           input logic [NB-1:0] s,
                           input logic [ADDR_W-1:0] ra);
        int bt = bdone + 1;
        int rt = rdone + 1;
        void'(exp_read(ra));
        exp_write(wa, dt, s);
        fork
            send_aw(wa, 0);
            send_w(dt, s, 0);
            send_ar(ra);
        join
        wait_b(bt);
        wait_r(rt);
    endtask

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        logic [129:0] e;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] ra;
        int op;
        int tgt;

        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0;
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick(3);
        check("rst_awready", {129'b0, bus.awready}, 130'd1);
        check("rst_wready",  {129'b0, bus.wready},  130'd1);
        check("rst_arready", {129'b0, bus.arready}, 130'd1);
        check("rst_bvalid",  {129'b0, bus.bvalid},  130'd0);
        check("rst_rvalid",  {129'b0, bus.rvalid},  130'd0);
        check("rst_bresp",   {128'b0, bus.bresp},   130'd0);
        check("rst_rresp",   {128'b0, bus.rresp},   130'd0);
        check("rst_rdata",   {2'b0, bus.rdata},     130'd0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < DEPTH; i++)
            do_write(ADDR_W'(i << 4), rnd128(), '1, 0);

        do_write(32'h10, 128'hDEADBEEF, 16'hFFFF, 0);
        do_read(32'h10);

        do_write(32'h20, 128'h12345678, 16'hFFFF, 0);
        do_write(32'h20, 128'hAAAA, 16'h0003, 3);
        do_read(32'h20);
        do_write(32'h20, rnd128(), 16'h0000, -2);
        do_read(32'h20);

        do_read(32'h100);
        do_write(32'h100, rnd128(), 16'hFFFF, 0);
        do_read(32'h000);

        bus.bready = 1'b0;
        tgt = bdone + 1;
        exp_write(32'h30, rnd128(), 16'hFFFF);
        fork
            send_aw(32'h30, 0);
            send_w(model[3], 16'hFFFF, 0);
        join
        repeat (5) begin
            @(negedge clk);
            check("bstall_bvalid",  {129'b0, bus.bvalid},  130'd1);
            check("bstall_bresp",   {128'b0, bus.bresp},   130'd0);
            check("bstall_awready", {129'b0, bus.awready}, 130'd0);
            check("bstall_wready",  {129'b0, bus.wready},  130'd0);
        end
        tick(1);
        bus.bready = 1'b1;
        wait_b(tgt);

        bus.rready = 1'b0;
        tgt = rdone + 1;
        e = exp_read(32'h3C);
        send_ar(32'h3C);
        repeat (5) begin
            @(negedge clk);
            check("rstall_rvalid", {129'b0, bus.rvalid}, 130'd1);
            check("rstall_data", {bus.rresp, bus.rdata}, e);
        end
        tick(1);
        bus.rready = 1'b1;
        wait_r(tgt);

        do_both(32'h40, rnd128(), 16'hFFFF, 32'h40);
        do_read(32'h40);

        bus.bready = 1'b0;
        exp_write(32'h50, rnd128(), 16'hFFFF);
        fork
            send_aw(32'h50, 0);
            send_w(model[5], 16'hFFFF, 0);
        join
        tick(1);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_bvalid",  {129'b0, bus.bvalid},  130'd0);
        check("rstw_awready", {129'b0, bus.awready}, 130'd1);
        check("rstw_wready",  {129'b0, bus.wready},  130'd1);
        check("rstw_arready", {129'b0, bus.arready}, 130'd1);
        tick(1);
        rst = 1'b0;
        bq.delete();
        bus.bready = 1'b1;
        tick(1);
        do_read(32'h50);

        send_w(rnd128(), 16'hFFFF, 0);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        do_write(32'h60, rnd128(), 16'hFFFF, -2);
        do_read(32'h60);

        bp_en = 1'b1;
        repeat (80) begin
            op = $urandom_range(0, 2);
            a  = ADDR_W'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0)
                a = a | (32'h1 << $urandom_range(8, 31));
            ra = ($urandom_range(0, 1) == 0) ? a
               : ADDR_W'($urandom_range(0, 255));
            case (op)
                0: do_write(a, rnd128(), NB'($urandom),
                            $urandom_range(0, 6) - 3);
                1: do_read(a);
                default: do_both(a, rnd128(), NB'($urandom), ra);
            endcase
        end
        bp_en = 1'b0;
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        tick(10);
        check("bq_drained", {98'b0, bq.size()}, 130'd0);
        check("rq_drained", {98'b0, rq.size()}, 130'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi4lite_slave_mem.md
AXI4LITE_SLAVE_MEM -- requirements
Module: axi4lite_slave_mem

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 128, data width; legal values are 32, 64 and 128.
REQ-003 Parameter DEPTH, default 16, number of DATA_W words; power of two, minimum 2.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 awaddr  in  ADDR_W  write address.
REQ-007 awvalid  in  1  write address valid.
REQ-008 awready  out  1  write address accepted.
REQ-009 wdata  in  DATA_W  write data.
REQ-010 wstrb  in  DATA_W/8  byte strobes.
REQ-011 wvalid  in  1  write data valid.
REQ-012 wready  out  1  write data accepted.
REQ-013 bresp  out  2  write response.
REQ-014 bvalid  out  1  write response valid.
REQ-015 bready  in  1  master accepts write response.
REQ-016 araddr  in  ADDR_W  read address.
REQ-017 arvalid  in  1  read address valid.
REQ-018 arready  out  1  read address accepted.
REQ-019 rdata  out  DATA_W  read data.
REQ-020 rresp  out  2  read response.
REQ-021 rvalid  out  1  read data valid.
REQ-022 rready  in  1  master accepts read data.

Function
REQ-023 Word index = addr[OFS +: log2(DEPTH)], where OFS = log2(DATA_W/8); the low OFS bits are ignored; any set bit above the index field makes the address out of range.
REQ-024 Write FSM states are W_IDLE and W_RESP; awready = W_IDLE and no AW held; wready = W_IDLE and no W held.
REQ-025 AW and W are each captured independently into a one-deep holding register on their handshake, in either order or in the same cycle.
REQ-026 On the edge where both AW and W are held (or arrive together), the write commits and the FSM enters W_RESP; bvalid is asserted the following cycle.
REQ-027 The write commit updates only the bytes whose wstrb bit is 1; wstrb = 0 commits nothing but still returns OKAY.
REQ-028 W_RESP holds bvalid and bresp stable until bvalid && bready, then returns to W_IDLE and clears both holding registers.
REQ-029 An in-range write returns bresp = 2'b00 (OKAY); an out-of-range write leaves the storage unchanged and returns 2'b10 (SLVERR).
REQ-030 Read FSM states are R_IDLE and R_DATA; arready = R_IDLE.
REQ-031 On the AR handshake, rdata and rresp are registered and the FSM enters R_DATA; rvalid is asserted the next cycle.
REQ-032 R_DATA holds rvalid, rdata and rresp stable until rvalid && rready; arready is reasserted the cycle after.
REQ-033 An out-of-range read returns rdata = 0 and rresp = 2'b10.
REQ-034 A read captured on the same edge as a write commit to the same word returns the pre-write data.
REQ-035 The read and write paths are fully independent; neither stalls the other.
REQ-036 No output depends combinationally on any input; every output is driven from a register.

Reset
REQ-037 While rst is high: both FSMs are in their IDLE states, holding registers are empty, awready = wready = arready = 1, bvalid = rvalid = 0, bresp = rresp = 0 and rdata = 0; storage contents are not reset.
REQ-038 Reset asserted mid-transaction abandons the transaction; a write already committed persists, and any half-captured AW or W is discarded.

Structure
REQ-039 Package axi4lite_pkg holds the RESP_OKAY and RESP_SLVERR constants and the wstate_t and rstate_t enums.
REQ-040 Storage is the single sub-module axi4lite_ram: one byte-enabled synchronous write port and one synchronous read port, parameterised by DATA_W and DEPTH.

Verification
REQ-041 After reset: AW 0x10 and W 0xDEADBEEF (wstrb 0xFFFF) in the same cycle -> bvalid 1 cycle later with bresp 00; AR 0x10 -> rdata 0xDEADBEEF, rresp 00.
REQ-042 W issued 3 cycles before AW to 0x20, then wstrb 0x0003 with wdata 0xAAAA over an old value 0x12345678 -> word reads 0x1234AAAA.
REQ-043 AR 0x100 (DEPTH 16, DATA_W 128) -> rresp 10, rdata 0; a write to 0x100 -> bresp 10 and storage unchanged.
REQ-044 bready held low for 5 cycles -> bvalid, bresp stable and awready/wready low throughout; rready low for 5 cycles -> rvalid, rdata, rresp stable.
REQ-045 Read and write to the same word on the same edge -> old data returned; reset pulsed during W_RESP -> bvalid 0 and all readies 1 while rst is high.
